// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises {cmd[1:0], payload} frames from MOSI for the RAM and serialises the RAM read reply MSB-first on MISO.
// Latency: rx_valid is registered on the edge that samples the last frame bit; the first MISO bit appears on the edge that samples tx_valid.
// Backpressure: none toward the master; the read reply waits indefinitely for tx_valid while SS_n stays low.
//
// Ports:
//   clk       serial/system clock, every register updates on its rising edge
//   rst       asynchronous active-high reset
//   SS_n      active-low slave select; a frame lives inside one low window
//   MOSI      serial data in, MSB first
//   MISO      registered serial data out, MSB first
//   rx_data   last complete frame; the top two bits are the command
//   rx_valid  one-cycle strobe marking a newly completed frame
//   tx_data   RAM read data
//   tx_valid  RAM read data valid, level-sampled while a read reply is pending
module spi_slave_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int FRAME = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(ADDR_SIZE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Progress inside a receive state. WRITE and READ_ADD go RX -> HOLD;
    // READ_DATA goes RX -> WAIT (for the RAM) -> SHIFT (MISO) -> HOLD.
    typedef enum logic [1:0] {
        PH_RX    = 2'd0,
        PH_WAIT  = 2'd1,
        PH_SHIFT = 2'd2,
        PH_HOLD  = 2'd3
    } phase_t;

    state_t                 state, state_nxt;
    phase_t                 phase, phase_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [FRAME-2:0]       rx_shift, rx_shift_nxt;
    logic [ADDR_SIZE-1:0]   tx_shift, tx_shift_nxt;
    logic                   rd_addr_seen, rd_addr_seen_nxt;
    logic                   miso_nxt;
    logic [FRAME-1:0]       rx_data_nxt;
    logic                   rx_valid_nxt;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= PH_RX;
            cnt          <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rd_addr_seen <= 1'b0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            cnt          <= cnt_nxt;
            rx_shift     <= rx_shift_nxt;
            tx_shift     <= tx_shift_nxt;
            rd_addr_seen <= rd_addr_seen_nxt;
            MISO         <= miso_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!SS_n) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)
                    state_nxt = IDLE;
                else if (!MOSI)
                    state_nxt = WRITE;          // commands 00 and 01
                else if (rd_addr_seen)
                    state_nxt = READ_DATA;
                else
                    state_nxt = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        phase_nxt        = phase;
        cnt_nxt          = cnt;
        rx_shift_nxt     = rx_shift;
        tx_shift_nxt     = tx_shift;
        rd_addr_seen_nxt = rd_addr_seen;
        miso_nxt         = 1'b0;
        rx_data_nxt      = rx_data;
        rx_valid_nxt     = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                phase_nxt = PH_RX;
            end

            CHK_CMD: begin
                // Command MSB is the first frame bit.
                if (!SS_n) begin
                    rx_shift_nxt = {rx_shift[FRAME-3:0], MOSI};
                    cnt_nxt      = CNT_W'(1);
                    phase_nxt    = PH_RX;
                end
            end

            WRITE, READ_ADD, READ_DATA: begin
                case (phase)
                    PH_RX: begin
                        // The last bit completes the frame even if SS_n
                        // rises on the same edge.
                        if (cnt == LAST_RX) begin
                            rx_data_nxt  = {rx_shift, MOSI};
                            rx_valid_nxt = 1'b1;
                            cnt_nxt      = '0;
                            phase_nxt    = (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                            if (state == READ_ADD) rd_addr_seen_nxt = 1'b1;
                        end else if (!SS_n) begin
                            rx_shift_nxt = {rx_shift[FRAME-3:0], MOSI};
                            cnt_nxt      = cnt + CNT_W'(1);
                        end
                    end

                    PH_WAIT: begin
                        // The MSB goes straight to MISO on the capture edge;
                        // the remaining bits are kept for the following cycles.
                        if (!SS_n && tx_valid) begin
                            miso_nxt     = tx_data[ADDR_SIZE-1];
                            tx_shift_nxt = {tx_data[ADDR_SIZE-2:0], 1'b0};
                            cnt_nxt      = CNT_W'(1);
                            phase_nxt    = PH_SHIFT;
                        end
                    end

                    PH_SHIFT: begin
                        if (cnt == LAST_TX) begin
                            // Every bit has been on the wire: reply finished.
                            rd_addr_seen_nxt = 1'b0;
                            cnt_nxt          = '0;
                            phase_nxt        = PH_HOLD;
                        end else begin
                            miso_nxt     = tx_shift[ADDR_SIZE-1];
                            tx_shift_nxt = {tx_shift[ADDR_SIZE-2:0], 1'b0};
                            cnt_nxt      = cnt + CNT_W'(1);
                        end
                    end

                    default: ;  // PH_HOLD: trailing MOSI bits are ignored
                endcase
            end

            default: ;
        endcase

        // Deselect ends the transaction from any state.
        if (SS_n) begin
            cnt_nxt   = '0;
            miso_nxt  = 1'b0;
            phase_nxt = PH_RX;
        end
    end

endmodule
